// File: rtl/event_dispatcher_if.sv
// Event-register bus between the key/button event producer and the dispatcher.
// Carries the event word, the clear acknowledge and all dispatcher state outputs.
// Modport slave is the dispatcher side; modport master is the producer/observer side.
interface event_dispatcher_if #(
  parameter int NUM_MENUS = 4,
  parameter int PARAM_W   = 4
);
  logic [7:0]                   evt;
  logic                         clear;
  logic                         note_on;
  logic                         note_off;
  logic [4:0]                   note_idx;
  logic [23:0]                  keys_held;
  logic [2:0]                   menu;
  logic [NUM_MENUS*PARAM_W-1:0] values;
  logic                         bad_evt;

  modport master (
    output evt,
    input  clear, note_on, note_off, note_idx, keys_held, menu, values, bad_evt
  );

  modport slave (
    input  evt,
    output clear, note_on, note_off, note_idx, keys_held, menu, values, bad_evt
  );
endinterface

// File: rtl/event_dispatcher.sv
// Consumer of the key/button event register: executes each event once, tracks held keys, menu and per-menu values.
// Latency: event sampled in IDLE at cycle N; clear, note pulses and state updates visible at N+2; one event per 3 cycles.
// Backpressure: none on the input; the producer holds evt until the one-cycle clear and then zeroes it.
// Option: define EVT_DISPATCH_VALUE_WRAP_EN to make increase/decrease wrap instead of saturate.
module event_dispatcher #(
  parameter int NUM_MENUS = 4,
  parameter int PARAM_W   = 4
) (
  input logic              clk,
  input logic              reset,
  event_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  localparam logic [2:0] T_PRESS   = 3'd1;
  localparam logic [2:0] T_RELEASE = 3'd2;
  localparam logic [2:0] T_INC     = 3'd3;
  localparam logic [2:0] T_DEC     = 3'd4;
  localparam logic [2:0] T_MENU    = 3'd5;

  localparam logic [2:0]         MENU_LAST = 3'(NUM_MENUS - 1);
  localparam logic [PARAM_W-1:0] VAL_ONE   = PARAM_W'(1);
  localparam logic [PARAM_W-1:0] VAL_MAX   = '1;

  state_t                       state;
  logic [7:0]                   evt_q;
  logic                         clear_q;
  logic                         note_on_q;
  logic                         note_off_q;
  logic [4:0]                   note_idx_q;
  logic [23:0]                  keys_q;
  logic [2:0]                   menu_q;
  logic [NUM_MENUS*PARAM_W-1:0] values_q;
  logic                         bad_q;

  logic [4:0]         key;
  logic               key_ok;
  logic [PARAM_W-1:0] cur_val;
  logic [PARAM_W-1:0] inc_val;
  logic [PARAM_W-1:0] dec_val;

  // Decode the captured event's key and the next value of the active menu's parameter.
  always_comb begin
    key     = evt_q[4:0];
    key_ok  = (evt_q[4:0] < 5'd24);
    cur_val = values_q[menu_q*PARAM_W +: PARAM_W];
`ifdef EVT_DISPATCH_VALUE_WRAP_EN
    inc_val = cur_val + VAL_ONE;
    dec_val = cur_val - VAL_ONE;
`else
    inc_val = (cur_val == VAL_MAX) ? cur_val : cur_val + VAL_ONE;
    dec_val = (cur_val == '0)      ? cur_val : cur_val - VAL_ONE;
`endif
  end

  // IDLE -> EXEC -> ACK sequencer; all effects are registered in EXEC so they appear with clear in ACK.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      evt_q      <= '0;
      clear_q    <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      note_idx_q <= '0;
      keys_q     <= '0;
      menu_q     <= '0;
      values_q   <= '0;
      bad_q      <= 1'b0;
    end else begin
      clear_q    <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      case (state)
        IDLE: begin
          // The input is read only here, so a held event cannot be executed twice.
          if (bus.evt[7:5] != 3'd0) begin
            evt_q <= bus.evt;
            state <= EXEC;
          end
        end
        EXEC: begin
          state   <= ACK;
          clear_q <= 1'b1;
          case (evt_q[7:5])
            T_PRESS: begin
              // A press of an already-held key is a typematic repeat and is ignored.
              if (key_ok && !keys_q[key]) begin
                keys_q[key] <= 1'b1;
                note_on_q   <= 1'b1;
                note_idx_q  <= key;
              end
            end
            T_RELEASE: begin
              if (key_ok && keys_q[key]) begin
                keys_q[key] <= 1'b0;
                note_off_q  <= 1'b1;
                note_idx_q  <= key;
              end
            end
            T_INC:  values_q[menu_q*PARAM_W +: PARAM_W] <= inc_val;
            T_DEC:  values_q[menu_q*PARAM_W +: PARAM_W] <= dec_val;
            T_MENU: menu_q <= (menu_q == MENU_LAST) ? 3'd0 : menu_q + 3'd1;
            3'd6, 3'd7: bad_q <= 1'b1;
            default: ;
          endcase
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.clear     = clear_q;
  assign bus.note_on   = note_on_q;
  assign bus.note_off  = note_off_q;
  assign bus.note_idx  = note_idx_q;
  assign bus.keys_held = keys_q;
  assign bus.menu      = menu_q;
  assign bus.values    = values_q;
  assign bus.bad_evt   = bad_q;

endmodule
